// File: rtl/ibus_responder.sv
// Instruction-bus responder: word memory plus an in-order pending queue that
// returns each fetched word a fixed LATENCY after its address is accepted.
package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

// One pending slot: captured word plus its countdown to readiness.
module ibus_pend_entry #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] word,
  output logic        rdy
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (wr) begin
      cnt  <= CW'(LATENCY - 1);
      word <= wdata;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign rdy = (cnt == '0);
endmodule

module ibus_responder
  import ibus_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 1,
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  input  logic        stall,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int OW = $clog2(MAX_PENDING + 1);

  logic [31:0] mem [MEM_WORDS];

  logic [IW-1:0] rd_idx, ld_idx;
  logic [31:0]   rd_word;

  logic [PW-1:0] head, tail;
  logic [OW-1:0] occ;
  logic          retire, accept;

  logic [MAX_PENDING-1:0][31:0] ent_word;
  logic [MAX_PENDING-1:0]       ent_rdy, ent_wr;

  // Address bits outside the word index are don't-care (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ireq.addr[31:IW+2], ireq.addr[1:0],
                              load_addr[31:IW+2], load_addr[1:0]};

  assign rd_idx  = ireq.addr[IW+1:2];
  assign ld_idx  = load_addr[IW+1:2];
  assign rd_word = mem[rd_idx];

  // Non-blocking write against the combinational read gives read-before-write.
  always_ff @(posedge clk) begin
    if (load_en) mem[ld_idx] <= load_data;
  end

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_PENDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign retire = ~reset & (occ != '0) & ent_rdy[head];
  assign accept = ireq.valid & ~stall & ~reset &
                  ((occ < OW'(MAX_PENDING)) | retire);

  always_comb begin
    ent_wr = '0;
    for (int i = 0; i < MAX_PENDING; i++)
      ent_wr[i] = accept & (tail == PW'(i));
  end

  for (genvar g = 0; g < MAX_PENDING; g++) begin : g_ent
    ibus_pend_entry #(.LATENCY(LATENCY)) u_ent (
      .clk   (clk),
      .reset (reset),
      .wr    (ent_wr[g]),
      .wdata (rd_word),
      .word  (ent_word[g]),
      .rdy   (ent_rdy[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (accept) tail <= inc_ptr(tail);
      if (retire) head <= inc_ptr(head);
      if (accept & ~retire)      occ <= occ + OW'(1);
      else if (retire & ~accept) occ <= occ - OW'(1);
    end
  end

  always_comb begin
    iresp         = '0;
    iresp.addr_ok = accept;
    iresp.data_ok = retire;
    iresp.data    = retire ? ent_word[head] : 32'h0;
  end
endmodule

// File: tb/tb_ibus_responder.sv
// Drives three responder configurations from one stimulus stream and checks
// every cycle against a timestamped scoreboard of expected responses.
module tb_ibus_responder;
  import ibus_pkg::*;

  typedef struct {
    logic [31:0] w;
    int          due;
  } sb_ent_t;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   req;
  logic        stall, load_en;
  logic [31:0] load_addr, load_data;
  ibus_resp_t  resp [3];

  int lat_k [3] = '{1, 3, 4};
  int mp_k  [3] = '{4, 4, 2};

  sb_ent_t     sb [3][$];
  logic [31:0] mmem [1024];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  ibus_responder #(.MEM_WORDS(1024), .LATENCY(1), .MAX_PENDING(4)) u_a (
    .clk(clk), .reset(reset), .ireq(req), .iresp(resp[0]), .stall(stall),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  ibus_responder #(.MEM_WORDS(1024), .LATENCY(3), .MAX_PENDING(4)) u_b (
    .clk(clk), .reset(reset), .ireq(req), .iresp(resp[1]), .stall(stall),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));
  ibus_responder #(.MEM_WORDS(1024), .LATENCY(4), .MAX_PENDING(2)) u_c (
    .clk(clk), .reset(reset), .ireq(req), .iresp(resp[2]), .stall(stall),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req.valid = 1'b0;
    repeat (n) tick();
  endtask

  // Per-cycle scoreboard: expected handshakes come from the model queue only.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic        edok, eaok;
      logic [31:0] edat;
      edok = !reset && sb[k].size() > 0 && sb[k][0].due == cyc;
      edat = edok ? sb[k][0].w : 32'h0;
      eaok = req.valid && !stall && !reset && (sb[k].size() < mp_k[k] || edok);
      chk($sformatf("addr_ok[%0d]", k), 32'(resp[k].addr_ok), 32'(eaok));
      chk($sformatf("data_ok[%0d]", k), 32'(resp[k].data_ok), 32'(edok));
      chk($sformatf("data[%0d]", k), resp[k].data, edat);
      if (reset) sb[k].delete();
      else begin
        if (edok) void'(sb[k].pop_front());
        if (eaok) sb[k].push_back('{mmem[(req.addr >> 2) & 32'h3FF], cyc + lat_k[k]});
      end
    end
    if (load_en) mmem[(load_addr >> 2) & 32'h3FF] = load_data;
    cyc++;
  end

  initial begin
    reset = 1'b1; req = '0; stall = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Preload words 0..15
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = 32'(i * 4);
      load_data = (i == 3) ? 32'h2402_0005 : (i == 4) ? 32'h1111_1111 : 32'hA500_0000 | 32'(i);
      tick();
    end
    load_en = 1'b0;
    idle(2);

    // Single fetch, LATENCY=1
    req = '{valid: 1'b1, addr: 32'h0000_000C};
    #3 chk("t1_aok", 32'(resp[0].addr_ok), 32'd1);
    tick();
    req.valid = 1'b0;
    #3 chk("t1_dok", 32'(resp[0].data_ok), 32'd1);
    chk("t1_data", resp[0].data, 32'h2402_0005);
    tick();
    #3 chk("t1_after", 32'(resp[0].data_ok), 32'd0);
    idle(6);

    // Back-to-back in order
    for (int i = 0; i < 4; i++) begin
      req = '{valid: 1'b1, addr: 32'(i * 4)};
      tick();
    end
    idle(8);

    // Full queue on the MAX_PENDING=2 instance
    for (int i = 0; i < 8; i++) begin
      req = '{valid: 1'b1, addr: 32'((i + 5) * 4)};
      #3;
      if (i == 2) chk("t3_full_aok", 32'(resp[2].addr_ok), 32'd0);
      if (i == 4) begin
        chk("t3_accret_aok", 32'(resp[2].addr_ok), 32'd1);
        chk("t3_accret_dok", 32'(resp[2].data_ok), 32'd1);
      end
      tick();
    end
    idle(10);

    // Stall, then wrap-around address
    req = '{valid: 1'b1, addr: 32'h0000_1004};
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    tick();
    idle(8);

    // Read-before-write
    req = '{valid: 1'b1, addr: 32'h0000_0010};
    load_en = 1'b1; load_addr = 32'h10; load_data = 32'hDEAD_BEEF;
    tick();
    req.valid = 1'b0; load_en = 1'b0;
    #3 chk("t5_old", resp[0].data, 32'h1111_1111);
    idle(6);
    req = '{valid: 1'b1, addr: 32'h0000_0010};
    tick();
    req.valid = 1'b0;
    #3 chk("t5_new", resp[0].data, 32'hDEAD_BEEF);
    idle(6);

    // Reset mid-flight
    req = '{valid: 1'b1, addr: 32'h0};
    tick();
    req.addr = 32'h4;
    tick();
    req.valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(4);
    req = '{valid: 1'b1, addr: 32'h8};
    tick();
    req.valid = 1'b0;
    tick();
    #3 chk("t6_early", 32'(resp[1].data_ok), 32'd0);
    tick();
    #3 chk("t6_dok", 32'(resp[1].data_ok), 32'd1);
    chk("t6_data", resp[1].data, 32'hA500_0002);
    idle(6);

    // Random traffic with stalls, loads and wrapped addresses
    for (int i = 0; i < 60; i++) begin
      req.valid = ($urandom_range(0, 3) != 0);
      req.addr  = 32'(($urandom_range(0, 7) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      stall     = ($urandom_range(0, 3) == 0);
      load_en   = ($urandom_range(0, 4) == 0);
      load_addr = 32'($urandom_range(0, 15) << 2);
      load_data = $urandom;
      tick();
    end
    stall = 1'b0; load_en = 1'b0;
    idle(10);

    for (int k = 0; k < 3; k++)
      chk($sformatf("drained[%0d]", k), 32'(sb[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
